audio_pwm_player: RTL and testbench
===================================

Name: audio_pwm_player

Overview:
- Downstream consumer of the sample-rate divider output `s_clk`. Each rising edge of `s_clk` marks one sample period.
- On each period the block requests one audio sample from an upstream source over a req/valid handshake.
- The accepted sample is played as PWM on a single pin that feeds the external RC-filter audio DAC.
- The block runs entirely in the system `clk` domain. `s_clk` is treated as an asynchronous level input and is never used as a clock.

Parameters:
- DATA_W, 8: sample width and PWM resolution (carrier = clk / 2^DATA_W).
- TIMEOUT, 1024: max clk cycles to wait for sample_valid after a request (>= 2).
- CNT_W, 16: width of the accepted-sample counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- s_clk  in  1  sample-rate square wave from the frequency divider.
- sample_data  in  DATA_W  unsigned sample from upstream.
- sample_valid  in  1  sample_data valid this cycle.
- underrun_clr  in  1  one-cycle clear of the underrun flag.
- sample_req  out  1  one-cycle pulse requesting the next sample.
- pwm_out  out  1  PWM audio output.
- underrun  out  1  sticky flag: a sample period passed without a sample being accepted.
- sample_cnt  out  CNT_W  number of accepted samples, wraps.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): all of the following clear to 0.
  - Synchronizer flops, FSM state (IDLE), timeout counter, pwm_cnt, duty, pending register and pending_full.
  - Outputs sample_req, pwm_out, underrun and sample_cnt.
- Tick detection:
  - s_clk passes through 2 sync flops plus 1 history flop; tick = sync2 & ~hist.
  - Tick is asserted for exactly 1 cycle, in the 3rd clk edge after s_clk rises.
  - Falling edges of s_clk are ignored.
- FSM, 3 states:
  - IDLE: on tick -> REQ. sample_valid is ignored in IDLE.
  - REQ: sample_req = 1 for exactly this one cycle (registered, so it appears 1 cycle after tick); then -> WAIT, with the timeout counter cleared.
  - WAIT: counter increments each cycle.
    - sample_valid = 1 -> capture sample_data into pending, set pending_full, sample_cnt += 1 (wraps at 2^CNT_W), -> IDLE.
    - Counter reaches TIMEOUT-1 without valid -> set underrun, -> IDLE; pending is unchanged.
  - sample_valid is accepted in both REQ and WAIT. Only the first valid is accepted; later valids are ignored until the next request.
  - Tick while in REQ or WAIT: set underrun and restart at REQ (new sample_req pulse). A valid in that same cycle is still accepted.
- PWM:
  - pwm_cnt is DATA_W bits, free-running, +1 every clk, wraps from all-ones to 0.
  - pwm_out is registered: pwm_out = (pwm_cnt < duty).
    - duty = 0 -> always low.
    - duty = 2^DATA_W-1 -> high 255 of every 256 cycles (DATA_W = 8).
  - duty loads only in the cycle pwm_cnt == all-ones, and only if pending_full is set; pending_full clears in that same cycle. This keeps each PWM frame glitch-free.
  - If a new sample is captured in the load cycle, it is written to pending and pending_full stays 1 for the next wrap.
  - A newer capture before the wrap overwrites pending (last value wins).
  - No new sample -> duty holds its previous value.
- underrun:
  - Sticky; cleared by underrun_clr.
  - Set and clear in the same cycle -> set wins.
- Latency:
  - s_clk rise -> sample_req: 4 clk cycles.
  - Accept -> duty update: at the next pwm_cnt wrap, 1-256 cycles.
  - duty -> pwm_out: 1 cycle.

Test Plan:
- Reset release, s_clk low, no stimulus -> sample_req, pwm_out, underrun and sample_cnt all remain 0 for 1000 cycles.
- s_clk rises at t0 -> sample_req high exactly at t0+4 cycles for 1 cycle. A falling edge of s_clk produces no pulse.
- After the request, sample_valid with data 0x40, 2 cycles later -> sample_cnt = 1. From the next wrap onward pwm_out is high exactly 64 of every 256 cycles. Repeat with data 0x00 (always low) and 0xFF (255/256 high).
- No sample_valid for 1024 cycles after sample_req -> underrun = 1 and duty unchanged. underrun_clr pulse -> 0. underrun_clr in the same cycle as a new timeout -> underrun stays 1.
- Second s_clk rise while still in WAIT -> underrun = 1 and a new sample_req is issued 4 cycles after the rise. A valid in the tick cycle is still counted.
- Assert reset mid-WAIT with duty = 0x80 -> pwm_out, duty, state and sample_cnt go to 0 immediately. The next s_clk rise after release gives normal request timing.

Source files
------------

// File: rtl/audio_pwm_player.sv
// audio_pwm_player
//   Requests one audio sample per rising edge of the sample-rate square wave
//   and plays the most recently accepted sample as PWM. Everything runs on clk.
//   s_clk is synchronised and edge-detected, and is never used as a clock.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   s_clk         sample-rate square wave (asynchronous level input)
//   sample_data   unsigned sample from upstream
//   sample_valid  sample_data valid this cycle
//   underrun_clr  one-cycle clear of the underrun flag
//   sample_req    one-cycle pulse requesting the next sample
//   pwm_out       PWM audio output (carrier = clk / 2^DATA_W)
//   underrun      sticky: a sample period ended without an accepted sample
//   sample_cnt    number of accepted samples (wraps)
module audio_pwm_player #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_clk,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              underrun_clr,
    output logic              sample_req,
    output logic              pwm_out,
    output logic              underrun,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              s_sync1;
    logic              s_sync2;
    logic              s_hist;
    logic              tick;

    logic [TO_W-1:0]   to_cnt;
    logic              accept;
    logic              timed_out;
    logic              set_underrun;

    logic [DATA_W-1:0] pwm_cnt;
    logic [DATA_W-1:0] duty;
    logic [DATA_W-1:0] pending;
    logic              pending_full;
    logic              frame_end;

    // Two-flop synchroniser plus history flop; rising edges only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_sync1 <= 1'b0;
            s_sync2 <= 1'b0;
            s_hist  <= 1'b0;
        end else begin
            s_sync1 <= s_clk;
            s_sync2 <= s_sync1;
            s_hist  <= s_sync2;
        end
    end

    assign tick = s_sync2 & ~s_hist;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state. A new tick always wins and restarts the request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (tick) next_state = REQ;
            end
            REQ: begin
                if (tick)              next_state = REQ;
                else if (sample_valid) next_state = IDLE;
                else                   next_state = WAIT;
            end
            WAIT: begin
                if (tick)              next_state = REQ;
                else if (sample_valid) next_state = IDLE;
                else if (timed_out)    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs / control strobes
    always_comb begin
        accept       = 1'b0;
        timed_out    = 1'b0;
        set_underrun = 1'b0;
        case (state)
            REQ: begin
                accept       = sample_valid;
                set_underrun = tick;
            end
            WAIT: begin
                accept       = sample_valid;
                timed_out    = (to_cnt == TO_LAST) && !sample_valid;
                set_underrun = tick || ((to_cnt == TO_LAST) && !sample_valid);
            end
            default: ;
        endcase
    end

    // Request pulse is registered from the REQ state, so it trails the tick by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_req <= 1'b0;
        end else begin
            sample_req <= (state == REQ);
        end
    end

    // Timeout counter: cleared while in REQ, counts every WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (set_underrun) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    // Pending buffer: a capture in the frame-end cycle still sets pending_full,
    // so the new sample loads at the following wrap while duty takes the old one.
    assign frame_end = (pwm_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (accept) begin
                pending      <= sample_data;
                pending_full <= 1'b1;
            end else if (frame_end) begin
                pending_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DATA_W'(1);
            if (frame_end && pending_full) begin
                duty <= pending;
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_audio_pwm_player.sv
module tb_audio_pwm_player;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 1024;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_clk;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              underrun_clr;
    logic              sample_req;
    logic              pwm_out;
    logic              underrun;
    logic [CNT_W-1:0]  sample_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: what has been accepted so far and what should be playing.
    int exp_cnt;
    int exp_duty;
    int exp_underrun;

    typedef struct {
        logic [7:0] data;
        int         dly;
        bit         dup;
        int         exp_high;
    } vec_t;

    vec_t vecs[5];

    audio_pwm_player #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_clk       (s_clk),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .underrun_clr(underrun_clr),
        .sample_req  (sample_req),
        .pwm_out     (pwm_out),
        .underrun    (underrun),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Any 256 consecutive cycles of constant duty hold exactly duty high cycles.
    task automatic measure(input string name, input int exp);
        int highs;
        highs = 0;
        repeat (260) @(negedge clk);
        repeat (256) begin
            @(negedge clk);
            if (pwm_out) highs++;
        end
        check(name, highs, exp);
    endtask

    // One sample period. dly < 0: never answer (timeout). dly = 0: valid in the
    // cycle before sample_req shows; dly = n: n cycles after that.
    task automatic txn(input string name, input logic [7:0] d, input int dly, input bit dup);
        int req_at;
        int req_n;
        int fall_req;
        req_at   = -1;
        req_n    = 0;
        fall_req = 0;
        s_clk = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sample_req) begin
                req_n++;
                if (req_at < 0) req_at = k;
            end
            sample_valid = 1'b0;
            if (dly >= 0 && k == 3 + dly) begin
                sample_valid = 1'b1;
                sample_data  = d;
            end
            if (dup && dly >= 0 && k == 5 + dly) begin
                sample_valid = 1'b1;
                sample_data  = ~d;
            end
        end
        sample_valid = 1'b0;
        s_clk = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (sample_req) fall_req++;
        end
        check({name, " req latency"}, req_at, 4);
        check({name, " req pulses"}, req_n, 1);
        check({name, " req on fall"}, fall_req, 0);
        if (dly >= 0) begin
            exp_cnt++;
            exp_duty = int'(d);
        end else begin
            repeat (TIMEOUT) @(negedge clk);
            exp_underrun = 1;
        end
        check({name, " sample_cnt"}, int'(sample_cnt), exp_cnt & 32'hFFFF);
        check({name, " underrun"}, int'(underrun), exp_underrun);
    endtask

    // Request with no answer; checks the exact timeout edge.
    task automatic timeout_seq(input string name, input bit clr_same);
        int req_at;
        req_at = -1;
        s_clk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (sample_req && req_at < 0) req_at = k;
        end
        check({name, " req latency"}, req_at, 4);
        s_clk = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        check({name, " underrun before edge"}, int'(underrun), 0);
        if (clr_same) underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check({name, " underrun at edge"}, int'(underrun), 1);
        exp_underrun = 1;
    endtask

    task automatic clear_underrun(input string name);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        exp_underrun = 0;
        check(name, int'(underrun), 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{data: 8'h40, dly: 2, dup: 1'b0, exp_high: 64};
        vecs[1] = '{data: 8'h00, dly: 1, dup: 1'b0, exp_high: 0};
        vecs[2] = '{data: 8'hFF, dly: 0, dup: 1'b0, exp_high: 255};
        vecs[3] = '{data: 8'h80, dly: 3, dup: 1'b1, exp_high: 128};
        vecs[4] = '{data: 8'h01, dly: 7, dup: 1'b1, exp_high: 1};

        reset        = 1'b1;
        s_clk        = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        exp_cnt      = 0;
        exp_duty     = 0;
        exp_underrun = 0;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sample_req || pwm_out || underrun || sample_cnt != '0) bad++;
        end
        check("idle outputs nonzero cycles", bad, 0);

        // Table-driven sample periods
        for (int i = 0; i < 5; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].dly, vecs[i].dup);
            measure($sformatf("vec%0d duty", i), vecs[i].exp_high);
        end

        // Timeout keeps duty, clear works, set wins over same-cycle clear
        timeout_seq("timeout", 1'b0);
        measure("duty after timeout", 1);
        clear_underrun("underrun_clr");
        timeout_seq("timeout+clr", 1'b1);
        @(negedge clk);
        check("underrun sticky", int'(underrun), 1);
        clear_underrun("underrun_clr 2");

        // Second s_clk rise while waiting; valid in the tick cycle still counts
        s_clk = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 4) check("rerise first req", int'(sample_req), 1);
            if (k == 5) s_clk = 1'b0;
            if (k == 10) s_clk = 1'b1;
            if (k == 12) begin
                sample_valid = 1'b1;
                sample_data  = 8'h33;
            end
            if (k == 13) begin
                sample_valid = 1'b0;
                check("rerise underrun", int'(underrun), 1);
                check("rerise tick-cycle accept", int'(sample_cnt), (exp_cnt + 1) & 32'hFFFF);
                check("rerise no early req", int'(sample_req), 0);
            end
            if (k == 14) begin
                check("rerise second req", int'(sample_req), 1);
                sample_valid = 1'b1;
                sample_data  = 8'h55;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        s_clk = 1'b0;
        exp_cnt += 2;
        exp_duty = 8'h55;
        exp_underrun = 1;
        check("rerise second accept", int'(sample_cnt), exp_cnt & 32'hFFFF);
        measure("rerise duty", 85);

        // Reset in the middle of WAIT with duty = 0x80
        txn("pre-reset", 8'h80, 1, 1'b0);
        measure("pre-reset duty", 128);
        s_clk = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 300 && !pwm_out; i++) @(negedge clk);
        check("pwm high before reset", int'(pwm_out), 1);
        #2 reset = 1'b1;
        #1;
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset sample_cnt", int'(sample_cnt), 0);
        check("reset underrun", int'(underrun), 0);
        check("reset sample_req", int'(sample_req), 0);
        s_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_cnt      = 0;
        exp_duty     = 0;
        exp_underrun = 0;
        measure("duty after reset", 0);
        txn("post-reset", 8'h20, 2, 1'b0);
        measure("post-reset duty", 32);

        // Randomised sample periods against the model
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            int r;
            int dly;
            bit dup;
            d   = 8'($urandom_range(0, 255));
            r   = int'($urandom_range(0, 9));
            dly = (r == 0) ? -1 : r - 1;
            dup = 1'($urandom_range(0, 1));
            txn($sformatf("rnd%0d", i), d, dly, dup);
            if (dly < 0) clear_underrun($sformatf("rnd%0d clr", i));
            measure($sformatf("rnd%0d duty", i), exp_duty);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
